// File: rtl/ahb_lite_cmd_master.sv
// ============================================================================
// Module   : ahb_lite_cmd_master
// Function : AHB-Lite manager that turns a valid/ready command stream into
//            pipelined single transfers with in-order responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_cmd_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   // command stream
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [DATA_W-1:0] cmd_wdata,
   // response stream
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   // AHB-Lite manager port
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic              HMASTLOCK,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic [1:0]        HRESP
);

   localparam logic [1:0] c_trans_idle   = 2'b00;
   localparam logic [1:0] c_trans_nonseq = 2'b10;
   localparam logic [1:0] c_resp_okay    = 2'b00;
   localparam logic [1:0] c_resp_error   = 2'b01;

   // Address-phase slot: the HADDR/HWRITE/HSIZE registers double as its payload
   logic              r_ap_valid;
   logic [DATA_W-1:0] r_ap_wdata;
   logic [ADDR_W-1:0] r_haddr;
   logic              r_hwrite;
   logic [2:0]        r_hsize;
   logic [1:0]        r_htrans;
   logic              r_cancel;

   // Data-phase slot
   logic              r_dp_valid;
   logic              r_dp_write;
   logic [DATA_W-1:0] r_hwdata;

   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic w_misaligned;
   logic w_addr_done;
   logic w_data_done;
   logic w_cancel_set;
   logic w_accept_aligned;
   logic w_accept_mis;
   logic w_resp_error;

   always_comb begin
      w_misaligned = (cmd_size > 3'd2)
                  || ((cmd_size == 3'd1) && cmd_addr[0])
                  || ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
      w_addr_done  = HREADY && (r_htrans == c_trans_nonseq);
      w_data_done  = r_dp_valid && HREADY;
      w_resp_error = (HRESP == c_resp_error);
      // First cycle of a two-cycle ERROR: pull the pending address phase back
      w_cancel_set = r_dp_valid && !HREADY && w_resp_error
                  && (r_htrans == c_trans_nonseq) && !r_cancel;
   end

   always_comb begin
      if (w_misaligned) begin
         cmd_ready = !r_ap_valid && !r_dp_valid && !r_cancel;
      end else begin
         cmd_ready = (!r_ap_valid || w_addr_done) && !r_cancel;
      end
      w_accept_aligned = cmd_valid && cmd_ready && !w_misaligned;
      w_accept_mis     = cmd_valid && cmd_ready &&  w_misaligned;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_ap_valid <= 1'b0;
         r_ap_wdata <= '0;
         r_haddr    <= '0;
         r_hwrite   <= 1'b0;
         r_hsize    <= 3'd0;
         r_htrans   <= c_trans_idle;
         r_cancel   <= 1'b0;
      end else begin
         if (w_accept_aligned) begin
            r_ap_valid <= 1'b1;
            r_ap_wdata <= cmd_wdata;
            r_haddr    <= cmd_addr;
            r_hwrite   <= cmd_write;
            r_hsize    <= cmd_size;
         end else if (w_addr_done) begin
            r_ap_valid <= 1'b0;
         end

         if (w_cancel_set) begin
            r_cancel <= 1'b1;
            r_htrans <= c_trans_idle;
         end else if (r_cancel && HREADY) begin
            // ERROR retired; the retained command goes out again
            r_cancel <= 1'b0;
            r_htrans <= c_trans_nonseq;
         end else if (w_accept_aligned) begin
            r_htrans <= c_trans_nonseq;
         end else if (w_addr_done) begin
            r_htrans <= c_trans_idle;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dp_valid  <= 1'b0;
         r_dp_write  <= 1'b0;
         r_hwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_addr_done) begin
            r_dp_valid <= 1'b1;
            r_dp_write <= r_hwrite;
            r_hwdata   <= r_hwrite ? r_ap_wdata : '0;
         end else if (w_data_done) begin
            r_dp_valid <= 1'b0;
         end

         // A misaligned accept only happens with an empty pipeline, so it never
         // collides with a data-phase retirement.
         r_rsp_valid <= w_data_done || w_accept_mis;
         r_rsp_err   <= w_accept_mis || (w_data_done && w_resp_error);
         r_rsp_rdata <= (w_data_done && !r_dp_write && (HRESP == c_resp_okay))
                        ? HRDATA : '0;
      end
   end

   assign HADDR     = r_haddr;
   assign HTRANS    = r_htrans;
   assign HWRITE    = r_hwrite;
   assign HSIZE     = r_hsize;
   assign HWDATA    = r_hwdata;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_cmd_master.sv
// ============================================================================
// Module   : tb_ahb_lite_cmd_master
// Function : Directed and random bench for ahb_lite_cmd_master with an AHB
//            memory slave and an in-order transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_cmd_master;

   logic        HCLK      = 1'b0;
   logic        HRESETn   = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [2:0]  cmd_size  = 3'd0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA = '0;
   logic        HREADY = 1'b1;
   logic [1:0]  HRESP  = 2'b00;

   ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc++;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- shared helpers ----------------
   logic [31:0] ref_mem [int];
   logic [31:0] bus_mem [int];

   function automatic logic [31:0] init_word(input int wa);
      return (32'(wa) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
   endfunction
   function automatic logic [31:0] rd_ref(input int wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction
   function automatic logic [31:0] rd_bus(input int wa);
      return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
   endfunction
   function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] lo);
      if (sz == 3'd0) return 4'b0001 << lo;
      if (sz == 3'd1) return 4'b0011 << lo;
      return 4'b1111;
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] mask);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction
   function automatic logic is_mis(input logic [2:0] sz, input logic [31:0] a);
      return (sz > 3'd2) || (sz == 3'd1 && a[0] != 1'b0) || (sz == 3'd2 && a[1:0] != 2'b00);
   endfunction
   function automatic logic in_err(input logic [31:0] a);
      return (a >= 32'hF0) && (a < 32'h100);
   endfunction

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];
   int   rsp_cyc[$];
   int   nacc = 0;

   always @(negedge HCLK) begin
      exp_t e;
      int   wa;
      if (!HRESETn) begin
         sb.delete();
      end else begin
         if (rsp_valid) begin
            rsp_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check("rsp_err", 32'(rsp_err), 32'(e.err));
               check("rsp_rdata", rsp_rdata, e.rdata);
            end
         end
         if (cmd_valid && cmd_ready) begin
            nacc++;
            e.err   = is_mis(cmd_size, cmd_addr) || in_err(cmd_addr);
            e.rdata = '0;
            wa = int'(cmd_addr >> 2);
            if (!e.err) begin
               if (cmd_write)
                  ref_mem[wa] = merge(rd_ref(wa), cmd_wdata, lane_mask(cmd_size, cmd_addr[1:0]));
               else
                  e.rdata = rd_ref(wa);
            end
            sb.push_back(e);
         end
      end
   end

   // ---------------- AHB memory slave ----------------
   int next_waits = -1;
   bit rand_waits = 1'b0;
   int naddr      = 0;

   logic        s_rst, s_write, s_ready;
   logic [1:0]  s_trans;
   logic [2:0]  s_size;
   logic [31:0] s_addr, s_wdata;
   logic        dp_act, dp_write, dp_err, dp_errph;
   logic [2:0]  dp_size;
   logic [31:0] dp_addr;
   int          dp_waits;

   initial begin : slave
      dp_act = 1'b0; dp_write = 1'b0; dp_err = 1'b0; dp_errph = 1'b0;
      dp_size = 3'd0; dp_addr = '0; dp_waits = 0;
      forever begin
         @(negedge HCLK);
         s_rst = HRESETn; s_trans = HTRANS; s_addr = HADDR; s_write = HWRITE;
         s_size = HSIZE; s_wdata = HWDATA; s_ready = HREADY;
         @(posedge HCLK);
         #1;
         if (!s_rst || !HRESETn) begin
            dp_act = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
         end else begin
            if (dp_act && s_ready) begin
               if (dp_write && !dp_err)
                  bus_mem[int'(dp_addr >> 2)] = merge(rd_bus(int'(dp_addr >> 2)), s_wdata,
                                                     lane_mask(dp_size, dp_addr[1:0]));
               dp_act = 1'b0;
            end
            if (s_trans == 2'b10 && s_ready) begin
               naddr++;
               dp_act = 1'b1; dp_addr = s_addr; dp_write = s_write; dp_size = s_size;
               dp_err = in_err(s_addr); dp_errph = 1'b0;
               if (next_waits >= 0) begin
                  dp_waits = next_waits; next_waits = -1;
               end else begin
                  dp_waits = rand_waits ? int'($urandom_range(0, 2)) : 0;
               end
            end
            if (!dp_act) begin
               HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
            end else if (dp_err) begin
               HRESP = 2'b01; HRDATA = '0;
               HREADY = dp_errph;
               dp_errph = 1'b1;
            end else if (dp_waits > 0) begin
               HREADY = 1'b0; HRESP = 2'b00; HRDATA = '0;
               dp_waits--;
            end else begin
               HREADY = 1'b1; HRESP = 2'b00;
               HRDATA = dp_write ? 32'h0 : rd_bus(int'(dp_addr >> 2));
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge HCLK);
      #2;
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, output int acc);
      logic ok;
      ok = 1'b0;
      acc = -1;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = d;
      for (int i = 0; i < 60; i++) begin
         @(negedge HCLK);
         ok = cmd_ready;
         @(posedge HCLK);
         #2;
         acc = cyc;
         if (ok) break;
      end
      if (!ok) check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
      check("drain", 32'(sb.size()), 32'd0);
      tick();
   endtask

   // ---------------- stimulus ----------------
   int          n, r, a, b, m, base, nbefore;
   int          acc4[4];
   logic [31:0] hw, wv, ra;
   logic [2:0]  rs;

   initial begin
      repeat (3) tick();
      check("rst_htrans", 32'(HTRANS), 32'd0);
      check("rst_haddr", HADDR, 32'd0);
      check("rst_hwrite", 32'(HWRITE), 32'd0);
      check("rst_hsize", 32'(HSIZE), 32'd0);
      check("rst_hwdata", HWDATA, 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("hburst", 32'(HBURST), 32'd0);
      check("hprot", 32'(HPROT), 32'd3);
      check("hmastlock", 32'(HMASTLOCK), 32'd0);
      HRESETn = 1'b1;
      tick();
      check("idle_ready", 32'(cmd_ready), 32'd1);

      // write then read back, zero wait
      send(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, n);
      check("wr_htrans", 32'(HTRANS), 32'd2);
      check("wr_haddr", HADDR, 32'h10);
      check("wr_hwrite", 32'(HWRITE), 32'd1);
      tick();
      check("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
      send(1'b0, 32'h10, 3'd2, 32'h0, r);
      check("rd_htrans", 32'(HTRANS), 32'd2);
      check("rd_hwrite", 32'(HWRITE), 32'd0);
      tick();
      tick();
      check("rd_latency_valid", 32'(rsp_valid), 32'd1);
      check("rd_latency_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("rd_latency_err", 32'(rsp_err), 32'd0);
      drain();

      // four back-to-back writes
      base = rsp_cyc.size();
      for (int i = 0; i < 4; i++) begin
         wv = $urandom;
         send(1'b1, 32'(4 * i), 3'd2, wv, acc4[i]);
         check("b2b_htrans", 32'(HTRANS), 32'd2);
         check("b2b_haddr", HADDR, 32'(4 * i));
         if (i > 0) check("b2b_accept_cycle", 32'(acc4[i]), 32'(acc4[i-1] + 1));
      end
      drain();
      for (int i = 0; i < 4; i++)
         check("b2b_rsp_cycle", 32'(rsp_cyc[base + i]), 32'(acc4[i] + 2));

      // two pipelined reads, two wait states on the first
      next_waits = 2;
      send(1'b0, 32'h0, 3'd2, 32'h0, a);
      send(1'b0, 32'h4, 3'd2, 32'h0, b);
      check("wait_accept_cycle", 32'(b), 32'(a + 1));
      check("wait1_hready", 32'(HREADY), 32'd0);
      check("wait1_haddr", HADDR, 32'h4);
      check("wait1_htrans", 32'(HTRANS), 32'd2);
      hw = HWDATA;
      tick();
      check("wait2_hready", 32'(HREADY), 32'd0);
      check("wait2_haddr", HADDR, 32'h4);
      check("wait2_htrans", 32'(HTRANS), 32'd2);
      check("wait2_hwdata", HWDATA, hw);
      drain();

      // ERROR on a write with a read to 0x20 waiting in the address phase
      send(1'b1, 32'hF0, 3'd2, $urandom, n);
      send(1'b0, 32'h20, 3'd2, 32'h0, r);
      check("err_accept_cycle", 32'(r), 32'(n + 1));
      check("err1_hresp", 32'(HRESP), 32'd1);
      check("err1_htrans", 32'(HTRANS), 32'd2);
      tick();
      check("err2_htrans", 32'(HTRANS), 32'd0);
      check("err2_ready", 32'(cmd_ready), 32'd0);
      tick();
      check("err_reissue_htrans", 32'(HTRANS), 32'd2);
      check("err_reissue_haddr", HADDR, 32'h20);
      check("err_rsp_err", 32'(rsp_err), 32'd1);
      drain();

      // misaligned command behind an in-flight read
      nbefore = naddr;
      send(1'b0, 32'h40, 3'd2, 32'h0, a);
      send(1'b0, 32'h6, 3'd2, 32'h0, m);
      check("mis_accept_cycle", 32'(m), 32'(a + 3));
      check("mis_htrans", 32'(HTRANS), 32'd0);
      check("mis_naddr", 32'(naddr), 32'(nbefore + 1));
      check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
      check("mis_rsp_err", 32'(rsp_err), 32'd1);
      check("mis_rsp_rdata", rsp_rdata, 32'd0);
      drain();

      // random traffic with random wait states
      rand_waits = 1'b1;
      for (int i = 0; i < 150; i++) begin
         rs = 3'($urandom_range(0, 9));
         rs = (rs >= 3'd8) ? 3'($urandom_range(3, 7)) : 3'(rs % 3);
         ra = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            if (rs == 3'd1) ra[0] = 1'b0;
            if (rs == 3'd2) ra[1:0] = 2'b00;
         end
         send(1'($urandom_range(0, 1)), ra, rs, $urandom, n);
         repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      check("rsp_count", 32'(rsp_cyc.size()), 32'(nacc));
      rand_waits = 1'b0;

      // reset during a write data phase
      next_waits = 3;
      send(1'b1, 32'h84, 3'd2, $urandom, n);
      tick();
      check("rst_pre_hready", 32'(HREADY), 32'd0);
      HRESETn = 1'b0;
      #1;
      check("rst_mid_htrans", 32'(HTRANS), 32'd0);
      check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_hwdata", HWDATA, 32'd0);
      tick();
      tick();
      HRESETn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("post_rst_htrans", 32'(HTRANS), 32'd0);
      end
      send(1'b0, 32'h10, 3'd2, 32'h0, n);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
